// File: rtl/instr_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder/loader.
// Range limits are only consulted when INSTR_ENC_RANGE_CHECK_EN is defined.
package instr_enc_pkg;

    typedef enum logic [1:0] {
        FMT_I = 2'b00,
        FMT_S = 2'b01,
        FMT_B = 2'b10,
        FMT_R = 2'b11
    } fmt_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_e;

    localparam int OPC_LSB = 0;
    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int F7_LSB  = 25;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int BOFF_MIN  = -4096;
    localparam int BOFF_MAX  = 4094;

endpackage

// File: rtl/instr_field_packer.sv
// Combinational RV32I field packer: fmt + fields -> 32-bit word, range_ok.
// Range checking is compiled in with INSTR_ENC_RANGE_CHECK_EN.
module instr_field_packer
    import instr_enc_pkg::*;
(
    input  fmt_e        fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        range_ok
);

    always_comb begin
        word = '0;
        word[OPC_LSB +: 7] = opcode;
        word[F3_LSB +: 3]  = funct3;
        word[RS1_LSB +: 5] = rs1;
        unique case (fmt)
            FMT_I: begin
                word[RD_LSB +: 5] = rd;
                word[31:20]       = imm[11:0];
            end
            FMT_S: begin
                word[RS2_LSB +: 5] = rs2;
                word[31:25]        = imm[11:5];
                word[11:7]         = imm[4:0];
            end
            FMT_B: begin
                word[RS2_LSB +: 5] = rs2;
                word[31]           = imm[12];
                word[30:25]        = imm[10:5];
                word[11:8]         = imm[4:1];
                word[7]            = imm[11];
            end
            FMT_R: begin
                word[RD_LSB +: 5]  = rd;
                word[RS2_LSB +: 5] = rs2;
                word[F7_LSB +: 7]  = funct7;
            end
        endcase
    end

`ifdef INSTR_ENC_RANGE_CHECK_EN
    logic signed [31:0] simm;
    assign simm = $signed(imm);

    always_comb begin
        range_ok = 1'b1;
        unique case (fmt)
            FMT_I, FMT_S:
                range_ok = (simm >= IMM12_MIN) && (simm <= IMM12_MAX);
            FMT_B:
                range_ok = (simm >= BOFF_MIN) && (simm <= BOFF_MAX) && !imm[0];
            FMT_R:
                range_ok = 1'b1;
        endcase
    end
`else
    // Out-of-field immediate bits are silently dropped in this build.
    logic unused_imm;
    assign unused_imm = ^{imm[31:13], imm[0]};
    assign range_ok   = 1'b1;
`endif

endmodule

// File: rtl/instr_encoder_loader.sv
// Boot/test program loader: encodes RV32I words and writes them to imem.
// Define INSTR_ENC_RANGE_CHECK_EN to reject out-of-range immediates.
module instr_encoder_loader
    import instr_enc_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [CNT_W-1:0]  instr_count,
    output logic              err
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              pend_q, pend_d;
    logic [31:0]       word;
    logic              range_ok;
    logic              in_hs;
    logic              reload;

    instr_field_packer u_packer (
        .fmt      (fmt_e'(fmt)),
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7   (funct7),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .imm      (imm),
        .word     (word),
        .range_ok (range_ok)
    );

    // start has priority over a same-cycle request in IDLE.
    assign in_ready = rst_n && (state_q == ST_IDLE) && !start;
    assign in_hs    = in_valid && in_ready;
    assign reload   = ((state_q == ST_IDLE) && start)
                   || ((state_q == ST_WRITE) && mem_ack && (start || pend_q));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        pend_d  = pend_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_hs && range_ok) begin
                    wdata_d = word;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (start) pend_d = 1'b1;
                if (mem_ack) begin
                    state_d = ST_IDLE;
                    pend_d  = 1'b0;
                    addr_d  = addr_q + ADDR_W'(4);
                    if (count_q != '1) count_d = count_q + CNT_W'(1);
                end
            end
        endcase
        if (reload) begin
            addr_d  = BASE_ADDR;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            count_q <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            pend_q  <= pend_d;
        end
    end

`ifdef INSTR_ENC_RANGE_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (reload) err_d = 1'b0;
        else if (in_hs && !range_ok) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign mem_we      = (state_q == ST_WRITE);
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader against a field-arithmetic model.
// Honours INSTR_ENC_RANGE_CHECK_EN for the range-rejection expectations.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        mem_ack = 1'b0;
    logic [1:0]  fmt = '0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [31:0] imm = '0;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [15:0] instr_count;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    bit [31:0] exp_addr = 0;
    int        exp_count = 0;
    bit        exp_err = 0;

    int bnd[10] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098, 3, -4};

    instr_encoder_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .fmt         (fmt),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .imm         (imm),
        .mem_we      (mem_we),
        .mem_ack     (mem_ack),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .instr_count (instr_count),
        .err         (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

    // Word built arithmetically from the RV32I field layout.
    function automatic bit [31:0] ref_word(
        input bit [1:0] f, input bit [6:0] op, input bit [2:0] f3,
        input bit [6:0] f7, input bit [4:0] d, input bit [4:0] s1,
        input bit [4:0] s2, input bit [31:0] im);
        bit [31:0] b;
        b = 32'(op) | (32'(f3) << 12) | (32'(s1) << 15);
        case (f)
            2'd0: return b | (32'(d) << 7) | ((im & 32'hFFF) << 20);
            2'd1: return b | (32'(s2) << 20) | (((im >> 5) & 32'h7F) << 25)
                           | ((im & 32'h1F) << 7);
            2'd2: return b | (32'(s2) << 20) | (((im >> 12) & 32'h1) << 31)
                           | (((im >> 5) & 32'h3F) << 25)
                           | (((im >> 1) & 32'hF) << 8)
                           | (((im >> 11) & 32'h1) << 7);
            default: return b | (32'(d) << 7) | (32'(s2) << 20) | (32'(f7) << 25);
        endcase
    endfunction

    function automatic bit ref_ok(input bit [1:0] f, input bit [31:0] im);
`ifdef INSTR_ENC_RANGE_CHECK_EN
        int v;
        v = int'(im);
        if (f == 2'd0 || f == 2'd1) return (v >= -2048) && (v <= 2047);
        if (f == 2'd2) return (v >= -4096) && (v <= 4094) && (v % 2 == 0);
        return 1'b1;
`else
        bit unused_args;
        unused_args = ^{f, im};
        return 1'b1;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_req(
        input bit [1:0] f, input bit [6:0] op, input bit [2:0] f3,
        input bit [6:0] f7, input bit [4:0] d, input bit [4:0] s1,
        input bit [4:0] s2, input bit [31:0] im);
        fmt = f; opcode = op; funct3 = f3; funct7 = f7;
        rd = d; rs1 = s1; rs2 = s2; imm = im;
        in_valid = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_addr = 0; exp_count = 0; exp_err = 0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #20;
        vectors++; if (in_ready !== 1'b0) begin miscompares++;
            $display("FAIL rst_ready got %b want 0", in_ready); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++;
            $display("FAIL rst_we got %b want 0", mem_we); end
        vectors++; if (mem_addr !== 32'h0) begin miscompares++;
            $display("FAIL rst_addr got %h want 0", mem_addr); end
        vectors++; if (mem_wdata !== 32'h0) begin miscompares++;
            $display("FAIL rst_wdata got %h want 0", mem_wdata); end
        vectors++; if (instr_count !== 16'h0) begin miscompares++;
            $display("FAIL rst_count got %0d want 0", instr_count); end
        vectors++; if (err !== 1'b0) begin miscompares++;
            $display("FAIL rst_err got %b want 0", err); end
        @(negedge clk) rst_n = 1'b1;
        tick();
        vectors++; if (in_ready !== 1'b1) begin miscompares++;
            $display("FAIL rst_ready_post got %b want 1", in_ready); end
    endtask

    task automatic test_i_basic();
        put_req(2'd0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        tick();
        in_valid = 1'b0;
        vectors++; if (mem_we !== 1'b1) begin miscompares++;
            $display("FAIL i_we got %b want 1", mem_we); end
        vectors++; if (mem_addr !== 32'h0) begin miscompares++;
            $display("FAIL i_addr got %h want 0", mem_addr); end
        vectors++; if (mem_wdata !== 32'h0050_0093) begin miscompares++;
            $display("FAIL i_wdata got %h want 00500093", mem_wdata); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++;
            $display("FAIL i_ready got %b want 0", in_ready); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        vectors++; if (mem_we !== 1'b0 || instr_count !== 16'd1) begin
            miscompares++;
            $display("FAIL i_done got we=%b cnt=%0d want we=0 cnt=1",
                     mem_we, instr_count); end
        vectors++; if (mem_addr !== 32'h4 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL i_next got addr=%h rdy=%b want 4 1",
                     mem_addr, in_ready); end
        exp_addr = 4; exp_count = 1;
    endtask

    task automatic test_start_wins();
        start = 1'b1;
        put_req(2'd0, 7'h13, 3'd0, 7'd0, 5'd2, 5'd2, 5'd0, 32'd1);
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++;
            $display("FAIL sw_ready got %b want 0", in_ready); end
        tick();
        start = 1'b0; in_valid = 1'b0;
        exp_addr = 0; exp_count = 0; exp_err = 0;
        vectors++; if (mem_we !== 1'b0) begin miscompares++;
            $display("FAIL sw_we got %b want 0", mem_we); end
        vectors++; if (mem_addr !== 32'h0 || instr_count !== 16'd0) begin
            miscompares++;
            $display("FAIL sw_rewind got addr=%h cnt=%0d want 0 0",
                     mem_addr, instr_count); end
    endtask

    task automatic test_back_to_back();
        put_req(2'd1, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
        tick();
        in_valid = 1'b0;
        vectors++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0020_A423) begin
            miscompares++;
            $display("FAIL s_word got %h@%h want 0020a423@0",
                     mem_wdata, mem_addr); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        put_req(2'd2, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
        vectors++; if (in_ready !== 1'b1) begin miscompares++;
            $display("FAIL b2b_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        vectors++; if (mem_we !== 1'b1 || mem_addr !== 32'h4
                       || mem_wdata !== 32'hFE20_8EE3) begin
            miscompares++;
            $display("FAIL b_word got we=%b %h@%h want 1 fe208ee3@4",
                     mem_we, mem_wdata, mem_addr); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        exp_addr = 8; exp_count = 2;
        vectors++; if (instr_count !== 16'd2 || mem_addr !== 32'h8) begin
            miscompares++;
            $display("FAIL sb_done got cnt=%0d addr=%h want 2 8",
                     instr_count, mem_addr); end
    endtask

    task automatic test_r_stall();
        put_req(2'd3, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'hDEAD_BEEF);
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (mem_we !== 1'b1 || mem_addr !== 32'h8
                || mem_wdata !== 32'h0020_81B3 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL r_stall%0d got we=%b %h@%h rdy=%b want 1 002081b3@8 0",
                         c, mem_we, mem_wdata, mem_addr, in_ready);
            end
            tick();
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        exp_addr = 12; exp_count = 3;
        vectors++; if (instr_count !== 16'd3 || mem_addr !== 32'hC
                       || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL r_done got cnt=%0d addr=%h rdy=%b want 3 c 1",
                     instr_count, mem_addr, in_ready); end
    endtask

    task automatic test_range();
`ifdef INSTR_ENC_RANGE_CHECK_EN
        put_req(2'd0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        tick();
        in_valid = 1'b0;
        vectors++; if (mem_we !== 1'b0 || err !== 1'b1) begin miscompares++;
            $display("FAIL rng_i got we=%b err=%b want 0 1", mem_we, err); end
        put_req(2'd2, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
        tick();
        in_valid = 1'b0;
        vectors++; if (mem_we !== 1'b0 || err !== 1'b1) begin miscompares++;
            $display("FAIL rng_b got we=%b err=%b want 0 1", mem_we, err); end
        vectors++; if (mem_addr !== 32'hC || instr_count !== 16'd3) begin
            miscompares++;
            $display("FAIL rng_hold got addr=%h cnt=%0d want c 3",
                     mem_addr, instr_count); end
        do_start();
        vectors++; if (err !== 1'b0 || mem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL rng_clr got err=%b addr=%h want 0 0", err, mem_addr); end
`else
        put_req(2'd0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        tick();
        in_valid = 1'b0;
        vectors++; if (mem_we !== 1'b1 || mem_wdata !== 32'h8000_0093
                       || mem_addr !== 32'hC) begin
            miscompares++;
            $display("FAIL trunc got we=%b %h@%h want 1 80000093@c",
                     mem_we, mem_wdata, mem_addr); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        exp_addr = 16; exp_count = 4;
        vectors++; if (err !== 1'b0 || instr_count !== 16'd4) begin
            miscompares++;
            $display("FAIL trunc_done got err=%b cnt=%0d want 0 4",
                     err, instr_count); end
`endif
    endtask

    task automatic test_start_in_write();
        bit [31:0] a;
        bit [31:0] w;
        a = exp_addr;
        w = ref_word(2'd0, 7'h13, 3'd0, 7'd0, 5'd5, 5'd6, 5'd0, 32'hFFFF_FFFF);
        put_req(2'd0, 7'h13, 3'd0, 7'd0, 5'd5, 5'd6, 5'd0, 32'hFFFF_FFFF);
        tick();
        in_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++; if (mem_we !== 1'b1 || mem_addr !== a || mem_wdata !== w) begin
            miscompares++;
            $display("FAIL sw1_pend got we=%b %h@%h want 1 %h@%h",
                     mem_we, mem_wdata, mem_addr, w, a); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        vectors++; if (mem_addr !== 32'h0 || instr_count !== 16'd0) begin
            miscompares++;
            $display("FAIL sw1_reload got addr=%h cnt=%0d want 0 0",
                     mem_addr, instr_count); end
        put_req(2'd3, 7'h33, 3'd7, 7'h20, 5'd9, 5'd10, 5'd11, 32'd0);
        tick();
        in_valid = 1'b0;
        start = 1'b1; mem_ack = 1'b1;
        tick();
        start = 1'b0; mem_ack = 1'b0;
        exp_addr = 0; exp_count = 0; exp_err = 0;
        vectors++; if (mem_addr !== 32'h0 || instr_count !== 16'd0
                       || mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL sw2_reload got addr=%h cnt=%0d we=%b want 0 0 0",
                     mem_addr, instr_count, mem_we); end
    endtask

    task automatic test_reset_mid_write();
        put_req(2'd0, 7'h13, 3'd1, 7'd0, 5'd7, 5'd8, 5'd0, 32'd12);
        tick();
        in_valid = 1'b0;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        put_req(2'd1, 7'h23, 3'd2, 7'd0, 5'd0, 5'd3, 5'd4, 32'd16);
        tick();
        in_valid = 1'b0;
        vectors++; if (mem_we !== 1'b1 || mem_addr !== 32'h4) begin
            miscompares++;
            $display("FAIL rmw_pre got we=%b addr=%h want 1 4", mem_we, mem_addr); end
        #1 rst_n = 1'b0;
        #1;
        vectors++; if (mem_we !== 1'b0) begin miscompares++;
            $display("FAIL rmw_we got %b want 0", mem_we); end
        vectors++; if (mem_addr !== 32'h0 || instr_count !== 16'd0) begin
            miscompares++;
            $display("FAIL rmw_state got addr=%h cnt=%0d want 0 0",
                     mem_addr, instr_count); end
        @(negedge clk) rst_n = 1'b1;
        tick();
        exp_addr = 0; exp_count = 0; exp_err = 0;
        vectors++; if (in_ready !== 1'b1 || mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL rmw_post got rdy=%b we=%b want 1 0", in_ready, mem_we); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 200; n++) begin
            bit [1:0]  f;
            bit [6:0]  op;
            bit [2:0]  f3;
            bit [6:0]  f7;
            bit [4:0]  d, s1, s2;
            bit [31:0] im, w;
            bit        ok;
            int        dly;
            f = 2'($urandom); op = 7'($urandom); f3 = 3'($urandom);
            f7 = 7'($urandom); d = 5'($urandom);
            s1 = 5'($urandom); s2 = 5'($urandom);
            case ($urandom_range(0, 3))
                0: im = 32'($urandom_range(0, 8191)) - 32'd4096;
                1: im = 32'(bnd[$urandom_range(0, 9)]);
                2: im = $urandom;
                default: im = (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
            endcase
            w = ref_word(f, op, f3, f7, d, s1, s2, im);
            ok = ref_ok(f, im);
            repeat ($urandom_range(0, 1)) tick();
            put_req(f, op, f3, f7, d, s1, s2, im);
            vectors++; if (in_ready !== 1'b1) begin miscompares++;
                $display("FAIL rnd%0d_ready got %b want 1", n, in_ready); end
            tick();
            in_valid = 1'b0;
            if (ok) begin
                dly = $urandom_range(0, 2);
                for (int c = 0; c <= dly; c++) begin
                    vectors++;
                    if (mem_we !== 1'b1 || mem_addr !== exp_addr
                        || mem_wdata !== w) begin
                        miscompares++;
                        $display("FAIL rnd%0d_wr got we=%b %h@%h want 1 %h@%h",
                                 n, mem_we, mem_wdata, mem_addr, w, exp_addr);
                    end
                    if (c < dly) tick();
                end
                mem_ack = 1'b1;
                tick();
                mem_ack = 1'b0;
                exp_addr += 4;
                if (exp_count < 65535) exp_count++;
            end else begin
                exp_err = 1'b1;
            end
            vectors++;
            if (mem_we !== 1'b0 || mem_addr !== exp_addr
                || instr_count !== 16'(exp_count) || err !== exp_err) begin
                miscompares++;
                $display("FAIL rnd%0d_post got we=%b a=%h c=%0d e=%b want 0 %h %0d %b",
                         n, mem_we, mem_addr, instr_count, err,
                         exp_addr, exp_count, exp_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_i_basic();
        test_start_wins();
        test_back_to_back();
        test_r_stall();
        test_range();
        test_start_in_write();
        test_reset_mid_write();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the core's immediate extraction path: packs opcode, register, funct and immediate fields into a 32-bit RV32I word.
- Supports R, I, S and B formats; each encoded word is written sequentially into instruction memory through a handshaked write port.
- Serves as the boot/test program loader ahead of the single-cycle core.
- Immediate bit placement is the exact inverse of the core's I/S/B immediate slicing.

Parameters:
- ADDR_W, 32, width of instruction-memory byte address.
- BASE_ADDR, 32'h0000_0000, first write address after reset or start.
- CNT_W, 16, width of the accepted-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; rewinds address to BASE_ADDR, clears count and err.
- in_valid  input  1  request valid.
- in_ready  output  1  encoder can accept a request.
- fmt  input  2  00=I, 01=S, 10=B, 11=R.
- opcode  input  7  instr[6:0].
- funct3  input  3  instr[14:12].
- funct7  input  7  instr[31:25], R only.
- rd  input  5  instr[11:7], R/I only.
- rs1  input  5  instr[19:15].
- rs2  input  5  instr[24:20], R/S/B only.
- imm  input  32  signed immediate; byte offset for B.
- mem_we  output  1  write request to instruction memory.
- mem_ack  input  1  memory accepted the write this cycle.
- mem_addr  output  ADDR_W  word-aligned byte address.
- mem_wdata  output  32  encoded instruction.
- instr_count  output  CNT_W  words written since reset/start.
- err  output  1  sticky: a request was rejected.

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=0; mem_we=0; mem_addr=BASE_ADDR; mem_wdata=0; instr_count=0; err=0.
- States:
  - IDLE: in_ready=1. A handshake (in_valid & in_ready) registers the encoded word.
    - Valid request -> WRITE.
    - Rejected request -> stays IDLE and sets err.
  - WRITE: in_ready=0; mem_we=1; mem_addr and mem_wdata held stable.
    - On mem_ack: mem_we=0; mem_addr += 4; instr_count += 1; -> IDLE.
- Latency: handshake at cycle N -> mem_we high at N+1. With mem_ack same cycle, next accept is possible at N+2 (throughput one word per 2 cycles).
- Encoding:
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - R: {funct7, rs2, rs1, funct3, rd, opcode}; imm ignored.
- Rejected requests consume the handshake only: no write, no address or count change.
- Wrap-around: mem_addr wraps modulo 2^ADDR_W. instr_count saturates at all-ones.
- start:
  - In IDLE: rewinds address, clears count and err the next cycle.
  - In WRITE: takes effect after mem_ack; the pending write completes at its original address, then address/count reload and no increment is applied.
  - Simultaneous start and handshake in IDLE: start wins and the request is not accepted (in_ready=0 that cycle).
- Reset mid-WRITE: write abandoned immediately; mem_we drops asynchronously.

Optional Feature:
- Macro: INSTR_ENC_RANGE_CHECK_EN.
- Defined: request rejected (err set) when:
  - I/S: imm not representable in 12-bit signed (-2048..2047).
  - B: imm outside -4096..4094, or imm[0]=1.
- Undefined: no checking; immediates silently truncated to the field bits; err tied 0.

Decomposition:
- Shared package instr_enc_pkg:
  - fmt encodings FMT_I/FMT_S/FMT_B/FMT_R (same values as the core's immediate-select codes).
  - State enum.
  - Field position constants.
  - Range limits IMM12_MIN/MAX, BOFF_MIN/MAX.
- One combinational sub-module instr_field_packer: fmt/fields -> {word, range_ok}. The top holds FSM, address counter and handshakes.

Test Plan:
- Reset, then I: opcode=0x13, rd=1, rs1=0, funct3=0, imm=5 -> mem_we at N+1, mem_addr=0x0, mem_wdata=0x00500093; after ack instr_count=1.
- S: opcode=0x23, funct3=2, rs1=1, rs2=2, imm=8, then B: opcode=0x63, funct3=0, rs1=1, rs2=2, imm=-4 -> words 0x0020A423 at 0x0 and 0xFE208EE3 at 0x4.
- R: opcode=0x33, rd=3, rs1=1, rs2=2, funct3=0, funct7=0 with mem_ack held low 3 cycles -> mem_we, mem_addr and mem_wdata=0x002081B3 stable throughout; in_ready=0 until ack.
- With INSTR_ENC_RANGE_CHECK_EN: I imm=2048, then B imm=3 -> no mem_we, err=1, mem_addr and instr_count unchanged. Without the macro: I imm=2048 writes 0x80000093 (rd=1, rs1=0).
- start pulsed during WRITE with pending ack, and rst_n asserted mid-WRITE -> pending word lands at its address, then mem_addr=BASE_ADDR and instr_count=0. Async reset drops mem_we without a clock edge.
